generic_multistage_pipelined_fifo: RTL and testbench



---
 rtl/generic_multistage_pipelined_fifo.sv | 162 ++++++++++++++++
 tb/tb_generic_multistage_pipelined_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/generic_multistage_pipelined_fifo.sv
// DEPTH-entry FIFO drained through a chain of PIPE_STAGES registered output stages.
// Optional sticky error flags: define GENERIC_PIPELINED_FIFO_ERR_FLAGS_EN.
module generic_multistage_pipelined_fifo #(
  parameter int GENERIC_FIFO_DEPTH      = 8,
  parameter int GENERIC_FIFO_THRESHOLD  = 6,
  parameter int GENERIC_FIFO_DATA_WIDTH = 32,
  parameter int PIPE_STAGES             = 2
) (
  input  logic                                               clk,
  input  logic                                               reset_poweron,
  input  logic                                               clear,
  input  logic                                               write,
  input  logic [GENERIC_FIFO_DATA_WIDTH-1:0]                 write_data,
  output logic                                               pipe_valid,
  input  logic                                               pipe_read,
  output logic [GENERIC_FIFO_DATA_WIDTH-1:0]                 pipe_data,
  output logic                                               almost_full,
  output logic                                               full,
  output logic [$clog2(GENERIC_FIFO_DEPTH+PIPE_STAGES+1)-1:0] occupancy
`ifdef GENERIC_PIPELINED_FIFO_ERR_FLAGS_EN
  ,
  output logic                                               overflow_err,
  output logic                                               underflow_err
`endif
);
  localparam int ADDR_WIDTH = $clog2(GENERIC_FIFO_DEPTH);
  localparam int OCC_WIDTH  = $clog2(GENERIC_FIFO_DEPTH + PIPE_STAGES + 1);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam int DW         = GENERIC_FIFO_DATA_WIDTH;
  localparam int P          = PIPE_STAGES;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(GENERIC_FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] THRESH_C = CNT_WIDTH'(GENERIC_FIFO_THRESHOLD);

  logic [DW-1:0]         mem [GENERIC_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [P-1:0]          valid_q, valid_d;
  logic [DW-1:0]         data_q [P];
  logic [DW-1:0]         data_d [P];
  logic [P-1:0]          adv;
  logic                  pop, rd_en, wr_en;
  logic [OCC_WIDTH-1:0]  stage_cnt;

  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= THRESH_C);
  assign pipe_valid  = valid_q[P-1];
  assign pipe_data   = data_q[P-1];
  assign pop         = valid_q[P-1] & pipe_read;
  // Writes into a full store are dropped even when a read frees a slot this cycle.
  assign wr_en       = write & ~full & ~clear;

  // Advance requests ripple back from the final stage so the chain moves as a unit.
  always_comb begin
    adv      = '0;
    adv[P-1] = pop;
    for (int k = P - 2; k >= 0; k--) begin
      adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
    end
  end

  assign rd_en = (count_q != '0) & (~valid_q[0] | adv[0]);

  // Next state for pointers, count and the stage chain; clear overrides all movement.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    data_d   = data_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
        valid_d[0] = 1'b1;
        data_d[0]  = mem[rd_ptr_q];
      end else if (adv[0]) begin
        valid_d[0] = 1'b0;
      end else begin
        valid_d[0] = valid_q[0];
      end
      for (int k = 1; k < P; k++) begin
        if (adv[k-1]) begin
          valid_d[k] = 1'b1;
          data_d[k]  = data_q[k-1];
        end else if (adv[k]) begin
          valid_d[k] = 1'b0;
        end else begin
          valid_d[k] = valid_q[k];
        end
      end
      count_d = count_q + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
    end
  end

  // Number of stages currently holding an item.
  always_comb begin
    stage_cnt = '0;
    for (int k = 0; k < P; k++) begin
      stage_cnt = stage_cnt + OCC_WIDTH'(valid_q[k]);
    end
  end

  assign occupancy = OCC_WIDTH'(count_q) + stage_cnt;

  // Control and stage registers.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int k = 0; k < P; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= write_data;
    end
  end

`ifdef GENERIC_PIPELINED_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags, cleared only by clear or reset.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (write & full);
      underflow_q <= underflow_q | (pipe_read & ~valid_q[P-1]);
    end
  end

  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;
`endif

endmodule

// File: tb/tb_generic_multistage_pipelined_fifo.sv
// Self-checking bench: directed vector table plus hand-written multi-cycle sequences.
module tb_generic_multistage_pipelined_fifo;

  logic        clk = 1'b0;
  logic        reset_poweron, clear, write, pipe_read;
  logic [31:0] write_data;
  logic        pipe_valid, almost_full, full;
  logic [31:0] pipe_data;
  logic [3:0]  occupancy;
`ifdef GENERIC_PIPELINED_FIFO_ERR_FLAGS_EN
  logic        overflow_err, underflow_err;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        wr;
    logic [31:0] wd;
    logic        rd;
    logic        clr;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  eocc;
    logic        efull;
    logic        eaf;
    logic        eovf;
    logic        eudf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  generic_multistage_pipelined_fifo #(
    .GENERIC_FIFO_DEPTH     (8),
    .GENERIC_FIFO_THRESHOLD (6),
    .GENERIC_FIFO_DATA_WIDTH(32),
    .PIPE_STAGES            (2)
  ) dut (
    .clk          (clk),
    .reset_poweron(reset_poweron),
    .clear        (clear),
    .write        (write),
    .write_data   (write_data),
    .pipe_valid   (pipe_valid),
    .pipe_read    (pipe_read),
    .pipe_data    (pipe_data),
    .almost_full  (almost_full),
    .full         (full),
    .occupancy    (occupancy)
`ifdef GENERIC_PIPELINED_FIFO_ERR_FLAGS_EN
    ,
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
`endif
  );

  function automatic void add(input logic wr, input logic [31:0] wd, input logic rd, input logic clr,
                              input logic ev, input logic [31:0] ed, input int eocc,
                              input logic efull, input logic eaf, input logic eovf, input logic eudf);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eocc = 4'(eocc);
    v.efull = efull; v.eaf = eaf; v.eovf = eovf; v.eudf = eudf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic eo, input logic eu);
`ifdef GENERIC_PIPELINED_FIFO_ERR_FLAGS_EN
    chk({name, "_ovf"}, 32'(overflow_err), 32'(eo));
    chk({name, "_udf"}, 32'(underflow_err), 32'(eu));
`endif
  endtask

  task automatic chk_basic(input string name, input logic ev, input logic [31:0] ed, input int eocc);
    chk({name, "_valid"}, 32'(pipe_valid), 32'(ev));
    if (ev) chk({name, "_data"}, pipe_data, ed);
    chk({name, "_occ"}, 32'(occupancy), 32'(eocc));
  endtask

  // Drive inputs away from the edge, then advance to 1 time unit past the next rising edge.
  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
    write = w; write_data = d; pipe_read = r; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 32'(pipe_valid), 32'h0);
    chk({name, "_data"}, pipe_data, 32'h0);
    chk({name, "_occ"}, 32'(occupancy), 32'h0);
    chk({name, "_full"}, 32'(full), 32'h0);
    chk({name, "_af"}, 32'(almost_full), 32'h0);
    chk_flags(name, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill latency: write driven after edge 1, visible at the output after edge 4.
    add(0, 32'h0,  0, 0, 0, 32'h0,  0, 0, 0, 0, 0);
    add(1, 32'hA5, 0, 0, 0, 32'h0,  1, 0, 0, 0, 0);
    add(0, 32'h0,  0, 0, 0, 32'h0,  1, 0, 0, 0, 0);
    add(0, 32'h0,  0, 0, 1, 32'hA5, 1, 0, 0, 0, 0);
    add(0, 32'h0,  1, 0, 0, 32'h0,  0, 0, 0, 0, 0);
    // Backpressure: 12 writes, 10 held (8 storage + 2 stages).
    for (int i = 1; i <= 12; i++) begin
      add(1, 32'h100 + 32'(i), 0, 0, i >= 3, 32'h101, (i < 10) ? i : 10,
          i >= 10, i >= 8, i >= 11, 0);
    end
    // Write while full with a simultaneous pop: the write is dropped.
    add(1, 32'h10D, 1, 0, 1, 32'h102, 9, 0, 1, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      add(0, 32'h0, 1, 0, k < 9, 32'h102 + 32'(k), 9 - k, 0, k <= 1, 1, 0);
    end

    reset_poweron = 1'b1;
    clear = 1'b0; write = 1'b0; pipe_read = 1'b0; write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_poweron = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      chk_basic($sformatf("t%0d", i), vecs[i].ev, vecs[i].ed, int'(vecs[i].eocc));
      chk($sformatf("t%0d_full", i), 32'(full), 32'(vecs[i].efull));
      chk($sformatf("t%0d_af", i), 32'(almost_full), 32'(vecs[i].eaf));
      chk_flags($sformatf("t%0d", i), vecs[i].eovf, vecs[i].eudf);
    end

    // Streaming: write and read every cycle; steady state holds 3 items.
    for (int n = 1; n <= 102; n++) begin
      step(1'b1, 32'h1000 + 32'(n - 1), 1'b1, 1'b0);
      if (n >= 3) chk_basic($sformatf("str%0d", n), 1'b1, 32'h1000 + 32'(n - 3), 3);
      else        chk_basic($sformatf("str%0d", n), 1'b0, 32'h0, n);
    end
    for (int n = 1; n <= 3; n++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("str_drain%0d_occ", n), 32'(occupancy), 32'(3 - n));
    end

    // Random traffic against a queue scoreboard; occupancy must equal items in flight.
    for (int c = 0; c < 400; c++) begin
      logic        w, r;
      logic [31:0] d;
      w = (sb.size() < 8) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) != 0);
      d = $urandom;
      if (pipe_valid && r) begin
        if (sb.size() == 0) chk("rnd_spurious", 32'(pipe_valid), 32'h0);
        else                chk("rnd_data", pipe_data, sb.pop_front());
      end
      if (w) sb.push_back(d);
      step(w, d, r, 1'b0);
      chk("rnd_occ", 32'(occupancy), 32'(sb.size()));
    end
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      if (pipe_valid) chk("rnd_drain_data", pipe_data, sb.pop_front());
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("rnd_drain_left", 32'(sb.size()), 32'h0);
    chk("rnd_drain_occ", 32'(occupancy), 32'h0);

    // Clear in the same cycle as write and read.
    step(1'b1, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b0, 1'b0);
    step(1'b1, 32'hC3, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_basic("pre_clr", 1'b1, 32'hC1, 3);
    chk_flags("pre_clr", 1'b1, 1'b1);
    step(1'b1, 32'hDEAD, 1'b1, 1'b1);
    chk_basic("clr", 1'b0, 32'h0, 0);
    chk("clr_full", 32'(full), 32'h0);
    chk("clr_af", 32'(almost_full), 32'h0);
    chk_flags("clr", 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk_basic($sformatf("post_clr%0d", n), 1'b0, 32'h0, 0);
    end
    step(1'b1, 32'hBEEF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_basic("clr_refill", 1'b1, 32'hBEEF, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_basic("clr_refill_pop", 1'b0, 32'h0, 0);

    // Read while empty: ignored, underflow flag sticky when built in.
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_basic("udf", 1'b0, 32'h0, 0);
    chk_flags("udf", 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_basic("udf_hold", 1'b0, 32'h0, 0);
    chk_flags("udf_hold", 1'b0, 1'b1);

    // Reset asserted mid-stream clears outputs without waiting for a clock edge.
    for (int n = 0; n < 4; n++) step(1'b1, 32'h71 + 32'(n), 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'h4);
    #2;
    reset_poweron = 1'b1;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    reset_poweron = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_all_zero("rst_release");
    step(1'b1, 32'h5A, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk_basic("rst_refill", 1'b1, 32'h5A, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
